// File: rtl/semaforo_pkg.sv
// Shared lamp encodings, phase codes and lamp decode for the intersection controller.
package semaforo_pkg;

  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERMELHO = 3'b100;

  typedef enum logic [2:0] {
    A_VERDE   = 3'd0,
    A_AMARELO = 3'd1,
    VERM_AB   = 3'd2,
    B_VERDE   = 3'd3,
    B_AMARELO = 3'd4,
    VERM_BA   = 3'd5,
    PEDESTRE  = 3'd6
  } fase_t;

  // Returns {road A lamps, road B lamps, walk lamp}; anything unknown shows all-red.
  function automatic logic [6:0] decodifica(fase_t f);
    case (f)
      A_VERDE:   return {VERDE,    VERMELHO, 1'b0};
      A_AMARELO: return {AMARELO,  VERMELHO, 1'b0};
      B_VERDE:   return {VERMELHO, VERDE,    1'b0};
      B_AMARELO: return {VERMELHO, AMARELO,  1'b0};
      PEDESTRE:  return {VERMELHO, VERMELHO, 1'b1};
      default:   return {VERMELHO, VERMELHO, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: pulses tick once every TICK_DIV clock cycles.
module divisor_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    tick  = (div_q == DIV_MAX);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/controle_cruzamento.sv
// Two-road intersection phase sequencer with a latched pedestrian request and walk phase.
module controle_cruzamento
  import semaforo_pkg::*;
#(
  parameter int T_VERDE     = 8,
  parameter int T_MIN_VERDE = 3,
  parameter int T_AMARELO   = 3,
  parameter int T_VERMELHO  = 1,
  parameter int T_PED       = 5,
  parameter int TICK_DIV    = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       P,
  output logic       pend,
  output logic [2:0] fase
);

  if (T_VERDE < 1 || T_MIN_VERDE < 1 || T_AMARELO < 1 || T_VERMELHO < 1 || T_PED < 1)
    begin : g_chk_min
      $error("controle_cruzamento: every T_* must be at least 1");
    end
  if (T_MIN_VERDE > T_VERDE) begin : g_chk_min_verde
    $error("controle_cruzamento: T_MIN_VERDE must not exceed T_VERDE");
  end
  if (T_VERDE > 2**CNT_W || T_AMARELO > 2**CNT_W || T_VERMELHO > 2**CNT_W || T_PED > 2**CNT_W)
    begin : g_chk_cnt_w
      $error("controle_cruzamento: a T_* value does not fit the phase counter");
    end
  if (TICK_DIV < 1) begin : g_chk_div
    $error("controle_cruzamento: TICK_DIV must be at least 1");
  end

  localparam logic [CNT_W-1:0] LIM_VERDE = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] LIM_MIN   = CNT_W'(T_MIN_VERDE - 1);
  localparam logic [CNT_W-1:0] LIM_AMAR  = CNT_W'(T_AMARELO - 1);
  localparam logic [CNT_W-1:0] LIM_VERM  = CNT_W'(T_VERMELHO - 1);
  localparam logic [CNT_W-1:0] LIM_PED   = CNT_W'(T_PED - 1);

  logic tick;

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  fase_t            state_q, state_d, prox;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             volta_q, volta_d;
  logic [2:0]       a_q, b_q;
  logic             p_q;
  logic             fim, ilegal, entra_ped;

  always_comb begin
    fim    = 1'b0;
    ilegal = 1'b0;
    prox   = A_VERDE;
    case (state_q)
      A_VERDE: begin
        fim  = (cnt_q == LIM_VERDE) || (pend_q && cnt_q >= LIM_MIN);
        prox = A_AMARELO;
      end
      A_AMARELO: begin
        fim  = (cnt_q == LIM_AMAR);
        prox = VERM_AB;
      end
      VERM_AB: begin
        fim  = (cnt_q == LIM_VERM);
        prox = pend_q ? PEDESTRE : B_VERDE;
      end
      B_VERDE: begin
        fim  = (cnt_q == LIM_VERDE) || (pend_q && cnt_q >= LIM_MIN);
        prox = B_AMARELO;
      end
      B_AMARELO: begin
        fim  = (cnt_q == LIM_AMAR);
        prox = VERM_BA;
      end
      VERM_BA: begin
        fim  = (cnt_q == LIM_VERM);
        prox = pend_q ? PEDESTRE : A_VERDE;
      end
      PEDESTRE: begin
        fim  = (cnt_q == LIM_PED);
        prox = volta_q ? B_VERDE : A_VERDE;
      end
      default: ilegal = 1'b1;
    endcase

    // An illegal code recovers immediately, without waiting for a tick.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ilegal) begin
      state_d = A_VERDE;
      cnt_d   = '0;
    end else if (tick && fim) begin
      state_d = prox;
      cnt_d   = '0;
    end else if (tick && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    entra_ped = (state_d == PEDESTRE) && (state_q != PEDESTRE);
    volta_d   = entra_ped ? (state_q == VERM_AB) : volta_q;
    pend_d    = entra_ped ? 1'b0 : (pend_q | (bt && state_q != PEDESTRE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_VERDE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      volta_q <= 1'b0;
      a_q     <= VERDE;
      b_q     <= VERMELHO;
      p_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      pend_q            <= pend_d;
      volta_q           <= volta_d;
      {a_q, b_q, p_q}   <= decodifica(state_d);
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign P    = p_q;
  assign pend = pend_q;
  assign fase = state_q;

endmodule

// File: tb/tb_controle_cruzamento.sv
// Scoreboard bench: a behavioural phase model predicts each cycle's outputs for two DUT builds.
module tb_controle_cruzamento;

  localparam int TV   = 4;
  localparam int TMIN = 2;
  localparam int TAM  = 2;
  localparam int TVM  = 1;
  localparam int TPED = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bt  = 1'b0;
  logic [2:0] a1, b1, f1, a2, b2, f2;
  logic       p1, pe1, p2, pe2;

  int n_checks = 0;
  int n_err    = 0;

  int m_st[2], m_cnt[2], m_div[2];
  bit m_pend[2], m_volta[2];
  int m_td[2] = '{1, 3};

  logic [10:0] sb1[$];
  logic [10:0] sb2[$];

  always #5 clk = ~clk;

  controle_cruzamento #(
    .T_VERDE(TV), .T_MIN_VERDE(TMIN), .T_AMARELO(TAM), .T_VERMELHO(TVM),
    .T_PED(TPED), .TICK_DIV(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .bt(bt), .A(a1), .B(b1), .P(p1), .pend(pe1), .fase(f1)
  );

  controle_cruzamento #(
    .T_VERDE(TV), .T_MIN_VERDE(TMIN), .T_AMARELO(TAM), .T_VERMELHO(TVM),
    .T_PED(TPED), .TICK_DIV(3), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst), .bt(1'b0), .A(a2), .B(b2), .P(p2), .pend(pe2), .fase(f2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advances the reference model of build k by one clock edge.
  task automatic modelStep(input int k, input bit r, input bit b);
    bit tk, fim, entra;
    int prox, lim;
    if (r) begin
      m_st[k] = 0; m_cnt[k] = 0; m_div[k] = 0; m_pend[k] = 0; m_volta[k] = 0;
      return;
    end
    tk = (m_div[k] == m_td[k] - 1);
    m_div[k] = tk ? 0 : m_div[k] + 1;
    case (m_st[k])
      0:       begin lim = TV;   prox = 1; end
      1:       begin lim = TAM;  prox = 2; end
      2:       begin lim = TVM;  prox = m_pend[k] ? 6 : 3; end
      3:       begin lim = TV;   prox = 4; end
      4:       begin lim = TAM;  prox = 5; end
      5:       begin lim = TVM;  prox = m_pend[k] ? 6 : 0; end
      default: begin lim = TPED; prox = m_volta[k] ? 3 : 0; end
    endcase
    fim = tk && ((m_cnt[k] + 1 == lim) ||
                 ((m_st[k] == 0 || m_st[k] == 3) && m_pend[k] && m_cnt[k] + 1 >= TMIN));
    entra = fim && (prox == 6);
    m_pend[k] = entra ? 1'b0 : (m_pend[k] | (b && m_st[k] != 6));
    if (entra) m_volta[k] = (m_st[k] == 2);
    if (fim) begin
      m_st[k]  = prox;
      m_cnt[k] = 0;
    end else if (tk) begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  function automatic logic [10:0] modelOut(input int k);
    logic [2:0] ea, eb;
    case (m_st[k])
      0:       begin ea = 3'b001; eb = 3'b100; end
      1:       begin ea = 3'b010; eb = 3'b100; end
      3:       begin ea = 3'b100; eb = 3'b001; end
      4:       begin ea = 3'b100; eb = 3'b010; end
      default: begin ea = 3'b100; eb = 3'b100; end
    endcase
    return {ea, eb, (m_st[k] == 6), m_pend[k], 3'(m_st[k])};
  endfunction

  // Drives one cycle of inputs, predicts the post-edge outputs and compares them mid-cycle.
  task automatic applyStimulus(input bit r, input bit b);
    rst = r;
    bt  = b;
    @(posedge clk);
    modelStep(0, r, b);
    modelStep(1, r, 1'b0);
    sb1.push_back(modelOut(0));
    sb2.push_back(modelOut(1));
    @(negedge clk);
    checkOutput("dut1_outputs", 32'({a1, b1, p1, pe1, f1}), 32'(sb1.pop_front()));
    checkOutput("dut2_outputs", 32'({a2, b2, p2, pe2, f2}), 32'(sb2.pop_front()));
  endtask

  initial begin
    int a_grn, b_grn, p_cnt;
    bit pend_in_walk;

    @(negedge clk);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("reset_A", 32'(a1), 32'(3'b001));
    checkOutput("reset_B", 32'(b1), 32'(3'b100));
    checkOutput("reset_P_pend_fase", 32'({p1, pe1, f1}), 32'(5'b0));

    // No requests: one 14-cycle period.
    a_grn = 0; b_grn = 0; p_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0);
      if (a1 == 3'b001) a_grn++;
      if (b1 == 3'b001) b_grn++;
      if (p1) p_cnt++;
    end
    checkOutput("period_A_green", 32'(a_grn), 32'(4));
    checkOutput("period_B_green", 32'(b_grn), 32'(4));
    checkOutput("period_no_walk", 32'(p_cnt), 32'(0));
    checkOutput("period_wraps", 32'(f1), 32'(0));

    // Request in the first green cycle shortens A green and inserts the walk phase.
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    checkOutput("req_pend_set", 32'(pe1), 32'(1));
    applyStimulus(0, 0);
    checkOutput("req_short_green", 32'(f1), 32'(1));
    b_grn = 0; p_cnt = 0; pend_in_walk = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, 0);
      if (p1) p_cnt++;
      if (p1 && pe1) pend_in_walk = 1;
      if (b1 == 3'b001) b_grn++;
    end
    checkOutput("req_walk_len", 32'(p_cnt), 32'(3));
    checkOutput("req_pend_clear", 32'(pend_in_walk), 32'(0));
    checkOutput("req_B_full_green", 32'(b_grn), 32'(4));
    checkOutput("req_back_to_A", 32'(f1), 32'(0));

    // Late request: green keeps its full length, walk still follows.
    applyStimulus(1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("late_green_full", 32'(f1), 32'(1));
    checkOutput("late_pend", 32'(pe1), 32'(1));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0);
    checkOutput("late_walk", 32'(f1), 32'(6));

    // Button held through the walk phase is ignored until the phase ends.
    applyStimulus(0, 1);
    checkOutput("walk_ignore_bt", 32'(pe1), 32'(0));
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("walk_exit_B", 32'(f1), 32'(3));
    checkOutput("walk_exit_pend0", 32'(pe1), 32'(0));
    applyStimulus(0, 1);
    checkOutput("after_walk_pend1", 32'(pe1), 32'(1));
    applyStimulus(0, 0);
    checkOutput("after_walk_short", 32'(f1), 32'(4));

    // Mid-phase reset during B yellow.
    applyStimulus(1, 0);
    checkOutput("midrst_outputs", 32'({a1, b1, p1, pe1, f1}), 32'({3'b001, 3'b100, 1'b0, 1'b0, 3'd0}));
    a_grn = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0);
      if (a1 == 3'b001) a_grn++;
    end
    checkOutput("midrst_A_green", 32'(a_grn), 32'(4));
    checkOutput("midrst_wraps", 32'(f1), 32'(0));

    // Prescaler build: every phase tripled, 42-cycle period.
    applyStimulus(1, 0);
    a_grn = 0; b_grn = 0;
    for (int i = 0; i < 42; i++) begin
      applyStimulus(0, 0);
      if (a2 == 3'b001) a_grn++;
      if (b2 == 3'b001) b_grn++;
    end
    checkOutput("div_A_green", 32'(a_grn), 32'(12));
    checkOutput("div_B_green", 32'(b_grn), 32'(12));
    checkOutput("div_wraps", 32'(f2), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
